hazard_fwd_unit: RTL

//  Hazard detection and forwarding control for the 5-stage pipeline. Tracks destination register

---
 rtl/hazard_fwd_unit_pkg.sv | 24 ++
 rtl/hazard_fwd_unit_if.sv | 26 ++
 rtl/hazard_fwd_unit_comparator_5.sv | 8 +
 rtl/hazard_fwd_unit.sv | 70 +++++++
 4 files changed

// File: rtl/hazard_fwd_unit_pkg.sv
// Shared types and constants for the hazard/forwarding unit.
package hazard_pkg;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       ld;
  } trk_entry_t;

  localparam trk_entry_t TRK_BUBBLE = '{v: 1'b0, rd: REG_ZERO, ld: 1'b0};

  // m[0]=EX, m[1]=MEM, m[2]=WB; youngest producer wins, WB is served by the regfile.
  function automatic logic [1:0] fwd_select(input logic [2:0] m, input logic ex_ld);
    if (m[0] && !ex_ld) return FWD_MEM;
    else if (m[1])      return FWD_WB;
    else                return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// Decode-side bundle: ID-stage operand info in, stall and forwarding selects out.
interface hazard_fwd_unit_if #(parameter int CNT_W = 32);
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_rs_used;
  logic             id_rt_used;
  logic [4:0]       id_rd;
  logic             id_wr_en;
  logic             id_is_load;
  logic             flush;
  logic             stall;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd, id_wr_en, id_is_load, flush,
    input  stall, fwd_a, fwd_b, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd, id_wr_en, id_is_load, flush,
    output stall, fwd_a, fwd_b, stall_count
  );
endinterface

// File: rtl/hazard_fwd_unit_comparator_5.sv
// 5-bit register-number equality compare.
module comparator_5 (
  input  logic [4:0] a,
  input  logic [4:0] b,
  output logic       eq
);
  assign eq = (a == b);
endmodule

// File: rtl/hazard_fwd_unit.sv
// Load-use stall (combinational) and registered EX forwarding selects from an EX/MEM/WB
// destination tracker; also counts stall cycles with saturation.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic               clk,
  input logic               rst_n,
  hazard_fwd_unit_if.slave  bus
);

  trk_entry_t       stage [3];   // 0=EX, 1=MEM, 2=WB
  trk_entry_t       id_ent;
  logic [2:0]       eq_rs, eq_rt;
  logic [2:0]       m_rs, m_rt;
  logic             stall_c;
  logic [1:0]       fwd_a_q, fwd_b_q;
  logic [CNT_W-1:0] cnt_q;

  for (genvar g = 0; g < 3; g++) begin : g_cmp
    comparator_5 u_cmp_rs (.a(bus.id_rs), .b(stage[g].rd), .eq(eq_rs[g]));
    comparator_5 u_cmp_rt (.a(bus.id_rt), .b(stage[g].rd), .eq(eq_rt[g]));

    assign m_rs[g] = stage[g].v & eq_rs[g] & bus.id_rs_used & bus.id_valid
                   & (bus.id_rs != REG_ZERO);
    assign m_rt[g] = stage[g].v & eq_rt[g] & bus.id_rt_used & bus.id_valid
                   & (bus.id_rt != REG_ZERO);
  end

  // Only an EX-stage load is unforwardable; one bubble moves it to MEM.
  assign stall_c = (m_rs[0] | m_rt[0]) & stage[0].ld & ~bus.flush;

  always_comb begin
    id_ent    = TRK_BUBBLE;
    id_ent.rd = bus.id_rd;
    id_ent.ld = bus.id_is_load;
    id_ent.v  = bus.id_valid & bus.id_wr_en & (bus.id_rd != REG_ZERO) & ~stall_c & ~bus.flush;
    if (!id_ent.v) id_ent = TRK_BUBBLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage[0] <= TRK_BUBBLE;
      stage[1] <= TRK_BUBBLE;
      stage[2] <= TRK_BUBBLE;
      fwd_a_q  <= FWD_RF;
      fwd_b_q  <= FWD_RF;
      cnt_q    <= '0;
    end else begin
      stage[0] <= id_ent;
      stage[1] <= stage[0];
      stage[2] <= stage[1];
      if (stall_c || bus.flush) begin
        fwd_a_q <= FWD_RF;
        fwd_b_q <= FWD_RF;
      end else begin
        fwd_a_q <= fwd_select(m_rs, stage[0].ld);
        fwd_b_q <= fwd_select(m_rt, stage[0].ld);
      end
      if (stall_c && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.stall       = stall_c;
  assign bus.fwd_a       = fwd_a_q;
  assign bus.fwd_b       = fwd_b_q;
  assign bus.stall_count = cnt_q;

endmodule
